// File: rtl/spi_ctrl_slave_if.sv
// Pin-side SPI signals plus the register-block handshake for spi_ctrl_slave.
interface spi_ctrl_slave_if;
    logic       SCK;
    logic       MOSI;
    logic       SS_N;
    logic       MISO;
    logic [6:0] SPI_ADDRESS;
    logic [7:0] SPI_DATA;
    logic       SPI_ENA;
    logic [7:0] DATA_TO_MISO;
    logic       FRAME_ERR;

    modport slave (
        input  SCK, MOSI, SS_N, DATA_TO_MISO,
        output MISO, SPI_ADDRESS, SPI_DATA, SPI_ENA, FRAME_ERR
    );

    modport master (
        output SCK, MOSI, SS_N, DATA_TO_MISO,
        input  MISO, SPI_ADDRESS, SPI_DATA, SPI_ENA, FRAME_ERR
    );
endinterface

// File: rtl/spi_ctrl_slave.sv
// SPI mode-0 slave: oversamples the pins in the CLK domain and turns 16-bit frames
// into register write strobes / read data on MISO.
module spi_ctrl_slave (
    input  logic CLK,
    input  logic RST,
    spi_ctrl_slave_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, TAIL, LOCKOUT} state_t;

    state_t      state;
    logic        sck_s1, sck_s2, sck_s3;
    logic        ss_s1, ss_s2, ss_s3;
    logic        mosi_s1, mosi_s2, mosi_d;
    logic        sck_rise, sck_fall, ss_rise, ss_fall;
    logic [14:0] shreg;
    logic [15:0] sh_next;
    logic [6:0]  miso_sh;
    logic [4:0]  cnt;
    logic        rw;
    logic        miso_q, ena_q, err_q;
    logic [6:0]  addr_q;
    logic [7:0]  data_q;

    // The 16th bit is consumed straight from sh_next, so 15 stored bits suffice.
    assign sh_next = {shreg, mosi_d};

    // Two-flop synchronisers, one extra stage for edges; edge flags are registered
    // so every output lands 4 CLK after the pin edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sck_s1 <= 1'b0; sck_s2 <= 1'b0; sck_s3 <= 1'b0;
            ss_s1 <= 1'b0; ss_s2 <= 1'b0; ss_s3 <= 1'b0;
            mosi_s1 <= 1'b0; mosi_s2 <= 1'b0; mosi_d <= 1'b0;
            sck_rise <= 1'b0; sck_fall <= 1'b0;
            ss_rise <= 1'b0; ss_fall <= 1'b0;
        end else begin
            sck_s1 <= bus.SCK;  sck_s2 <= sck_s1;  sck_s3 <= sck_s2;
            ss_s1 <= bus.SS_N;  ss_s2 <= ss_s1;    ss_s3 <= ss_s2;
            mosi_s1 <= bus.MOSI; mosi_s2 <= mosi_s1; mosi_d <= mosi_s2;
            sck_rise <= sck_s2 & ~sck_s3;
            sck_fall <= ~sck_s2 & sck_s3;
            ss_rise <= ss_s2 & ~ss_s3;
            ss_fall <= ~ss_s2 & ss_s3;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // Synchronisers clear to 0, i.e. SS_N reads low: park in LOCKOUT until
            // the real level has propagated, so a frame in flight is never decoded.
            state   <= LOCKOUT;
            shreg   <= '0;
            miso_sh <= '0;
            cnt     <= '0;
            rw      <= 1'b0;
            miso_q  <= 1'b0;
            ena_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            ena_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (ss_fall) begin
                        state <= HDR;
                        cnt   <= '0;
                        shreg <= '0;
                    end
                end
                HDR, DATA: begin
                    if (ss_rise) begin
                        err_q  <= 1'b1;
                        miso_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        if (sck_rise) begin
                            shreg <= sh_next[14:0];
                            cnt   <= cnt + 5'd1;
                            if (state == HDR && cnt == 5'd7) begin
                                rw     <= sh_next[7];
                                addr_q <= sh_next[6:0];
                                state  <= DATA;
                            end
                            if (state == DATA && cnt == 5'd15) begin
                                if (!sh_next[15]) begin
                                    data_q <= sh_next[7:0];
                                    ena_q  <= 1'b1;
                                end
                                miso_q <= 1'b0;
                                state  <= TAIL;
                            end
                        end
                        // Rise and fall are never flagged in the same cycle.
                        if (state == DATA && sck_fall && rw) begin
                            if (cnt == 5'd8) begin
                                miso_sh <= bus.DATA_TO_MISO[6:0];
                                miso_q  <= bus.DATA_TO_MISO[7];
                            end else begin
                                miso_sh <= {miso_sh[5:0], 1'b0};
                                miso_q  <= miso_sh[6];
                            end
                        end
                    end
                end
                TAIL: begin
                    miso_q <= 1'b0;
                    if (ss_rise) state <= IDLE;
                end
                LOCKOUT: begin
                    miso_q <= 1'b0;
                    if (ss_s2) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (ss_s2) miso_q <= 1'b0;
        end
    end

    assign bus.MISO        = miso_q;
    assign bus.SPI_ADDRESS = addr_q;
    assign bus.SPI_DATA    = data_q;
    assign bus.SPI_ENA     = ena_q;
    assign bus.FRAME_ERR   = err_q;
endmodule

// File: tb/tb_spi_ctrl_slave.sv
// Bench for spi_ctrl_slave: directed frame table, reset-in-frame sequence, and
// random frames scored against a frame-level model.
module tb_spi_ctrl_slave;
    logic CLK = 1'b0;
    logic RST;
    int   cyc = 0;

    spi_ctrl_slave_if bus();
    spi_ctrl_slave dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Register block stand-in: read data registered one CLK after the address.
    logic [7:0] rd_mem [128];
    always @(posedge CLK) bus.DATA_TO_MISO <= rd_mem[bus.SPI_ADDRESS];

    int checks = 0, errors = 0;
    int ena_hi = 0, err_hi = 0, both_hi = 0;
    int ena_cyc = 0, rise16_cyc = 0;
    logic [14:0] ena_pairs[$];

    always @(negedge CLK) begin
        if (bus.SPI_ENA) begin
            ena_hi++;
            ena_cyc = cyc;
            ena_pairs.push_back({bus.SPI_ADDRESS, bus.SPI_DATA});
        end
        if (bus.FRAME_ERR) err_hi++;
        if (bus.SPI_ENA && bus.FRAME_ERR) both_hi++;
    end

    typedef struct {
        logic [31:0] bits;   // frame bits, MSB-first, left aligned
        int          nbits;
        int          half;
        int          gap;
        int          exp_ena;
        int          exp_err;
        logic [6:0]  exp_addr;
        logic [7:0]  exp_data;
        logic [7:0]  exp_miso;
    } vec_t;

    vec_t       tbl [10];
    logic [6:0] m_addr;
    logic [7:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic spi_frame(input logic [31:0] bits, input int nbits, input int half,
                             input int gap, input int rst_after,
                             output logic [7:0] miso_b, output logic miso_x);
        miso_b = '0;
        miso_x = 1'b0;
        bus.SS_N = 1'b0;
        wait_clk(6);
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = bits[31-i];
            wait_clk(half);
            if (i >= 8 && i < 16) miso_b[15-i] = bus.MISO;
            else if (i >= 16) miso_x = miso_x | bus.MISO;
            bus.SCK = 1'b1;
            if (i == 15) rise16_cyc = cyc;
            if (i + 1 == rst_after) begin
                wait_clk(1);
                RST = 1'b1;
                wait_clk(1);
                RST = 1'b0;
                wait_clk(half - 2);
            end else begin
                wait_clk(half);
            end
            bus.SCK = 1'b0;
        end
        wait_clk(6);
        bus.SS_N = 1'b1;
        wait_clk(gap);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int e0, r0;
        logic [7:0] mb;
        logic mx;
        logic [14:0] pr;
        e0 = ena_hi;
        r0 = err_hi;
        spi_frame(v.bits, v.nbits, v.half, v.gap, 0, mb, mx);
        chk({tag, " ena_cycles"}, ena_hi - e0, v.exp_ena);
        chk({tag, " frame_err"}, err_hi - r0, v.exp_err);
        chk({tag, " addr"}, bus.SPI_ADDRESS, v.exp_addr);
        chk({tag, " data"}, bus.SPI_DATA, v.exp_data);
        chk({tag, " miso_byte"}, mb, v.exp_miso);
        chk({tag, " miso_tail"}, mx, 0);
        chk({tag, " miso_idle"}, bus.MISO, 0);
        if (v.exp_ena != 0) begin
            chk({tag, " ena_latency"}, ena_cyc - rise16_cyc, 4);
            pr = (ena_pairs.size() > 0) ? ena_pairs.pop_front() : 15'h7fff;
            chk({tag, " ena_pair"}, pr, {v.exp_addr, v.exp_data});
        end
        ena_pairs.delete();
        m_addr = v.exp_addr;
        m_data = v.exp_data;
    endtask

    // Frame-level model: what the register side should see once a frame of
    // nbits bits has completed or been cut short.
    task automatic run_model(input logic [31:0] bits, input int nbits, input int half,
                             input int gap, input string tag);
        vec_t v;
        int   k;
        logic [7:0] mask;
        v.bits = bits; v.nbits = nbits; v.half = half; v.gap = gap;
        v.exp_ena  = (nbits >= 16 && !bits[31]) ? 1 : 0;
        v.exp_err  = (nbits < 16) ? 1 : 0;
        v.exp_addr = (nbits >= 8) ? bits[30:24] : m_addr;
        v.exp_data = (v.exp_ena != 0) ? bits[23:16] : m_data;
        k = ((nbits > 16) ? 16 : nbits) - 8;
        mask = (k > 0) ? ~(8'hFF >> k) : 8'h00;
        v.exp_miso = (bits[31] && k > 0) ? (rd_mem[bits[30:24]] & mask) : 8'h00;
        run_vec(v, tag);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] mb;
        logic mx;
        int e0, r0;
        for (int a = 0; a < 128; a++) rd_mem[a] = 8'h40 + 8'(a);

        tbl[0] = '{32'h05A3_0000, 16, 6, 10, 1, 0, 7'h05, 8'hA3, 8'h00};
        tbl[1] = '{32'h8C00_0000, 16, 6, 10, 0, 0, 7'h0C, 8'hA3, 8'h4C};
        tbl[2] = '{32'h07FF_0000, 11, 6, 10, 0, 1, 7'h07, 8'hA3, 8'h00};
        tbl[3] = '{32'h020F_0000, 16, 7, 10, 1, 0, 7'h02, 8'h0F, 8'h00};
        tbl[4] = '{32'h0355_FF00, 24, 6, 10, 1, 0, 7'h03, 8'h55, 8'h00};
        tbl[5] = '{32'h0010_0000, 16, 6,  6, 1, 0, 7'h00, 8'h10, 8'h00};
        tbl[6] = '{32'h0111_0000, 16, 6,  6, 1, 0, 7'h01, 8'h11, 8'h00};
        tbl[7] = '{32'h0212_0000, 16, 6,  6, 1, 0, 7'h02, 8'h12, 8'h00};
        tbl[8] = '{32'h0313_0000, 16, 6,  6, 1, 0, 7'h03, 8'h13, 8'h00};
        tbl[9] = '{32'h8300_0000, 16, 8, 10, 0, 0, 7'h03, 8'h13, 8'h43};

        RST = 1'b1;
        bus.SS_N = 1'b1;
        bus.SCK  = 1'b0;
        bus.MOSI = 1'b0;
        wait_clk(4);
        RST = 1'b0;
        wait_clk(1);
        chk("reset MISO", bus.MISO, 0);
        chk("reset SPI_ADDRESS", bus.SPI_ADDRESS, 0);
        chk("reset SPI_DATA", bus.SPI_DATA, 0);
        chk("reset SPI_ENA", bus.SPI_ENA, 0);
        chk("reset FRAME_ERR", bus.FRAME_ERR, 0);
        wait_clk(10);

        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset lands mid-frame; the rest of that frame must be ignored.
        e0 = ena_hi;
        r0 = err_hi;
        spi_frame(32'h0A5A_0000, 16, 6, 10, 5, mb, mx);
        chk("rstmid ena", ena_hi - e0, 0);
        chk("rstmid err", err_hi - r0, 0);
        chk("rstmid addr", bus.SPI_ADDRESS, 0);
        chk("rstmid data", bus.SPI_DATA, 0);
        chk("rstmid miso", {mb, bus.MISO}, 0);
        ena_pairs.delete();
        m_addr = '0;
        m_data = '0;
        run_model(32'h010C_0000, 16, 6, 10, "post_rst");

        for (int a = 0; a < 128; a++) rd_mem[a] = 8'($urandom);
        for (int n = 0; n < 40; n++) begin
            logic [31:0] b;
            int nb;
            b  = $urandom;
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24)) : 16;
            run_model(b, nb, int'($urandom_range(6, 9)), int'($urandom_range(6, 10)),
                      $sformatf("rnd%0d", n));
        end

        chk("ena_err_overlap", both_hi, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
